// File: rtl/route_reg_arbiter_if.sv
// Bus between requesters and the shared route-register arbiter.
// Master drives requests/data/release; slave (the arbiter) drives grant and write port.
interface route_reg_arbiter_if #(
    parameter int N_REQ = 5,
    parameter int DW    = 3
);
    logic [N_REQ-1:0]    req_i;
    logic [N_REQ*DW-1:0] data_i;
    logic [N_REQ-1:0]    release_i;
    logic [N_REQ-1:0]    gnt_o;
    logic                en_o;
    logic [DW-1:0]       write_o;
    logic [2:0]          owner_o;
    logic                busy_o;

    modport master (
        output req_i, data_i, release_i,
        input  gnt_o, en_o, write_o, owner_o, busy_o
    );

    modport slave (
        input  req_i, data_i, release_i,
        output gnt_o, en_o, write_o, owner_o, busy_o
    );
endinterface

// File: rtl/route_reg_arbiter.sv
// Round-robin owner arbiter for a shared route register: one-cycle write strobe
// on grant, ownership held until the owner's release strobe.
module route_reg_arbiter #(
    parameter int N_REQ = 5,
    parameter int DW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    route_reg_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             en_q, en_d;
    logic [DW-1:0]    write_q, write_d;
    logic [2:0]       owner_q, owner_d;
    logic             busy_q, busy_d;

    logic [2:0]       win_idx;
    logic             win_found;
    logic             rel_own;

    // First requester at or above ptr, wrapping back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && bus.req_i[(int'(ptr_q) + i) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = 3'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    // gnt_q is one-hot at the owner, so masking picks the owner's release only.
    assign rel_own = |(bus.release_i & gnt_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        en_d    = 1'b0;
        write_d = write_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (win_found) begin
                    state_d = LOAD;
                    gnt_d   = N_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    write_d = bus.data_i[win_idx*DW +: DW];
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LOAD, HOLD: begin
                state_d = HOLD;
                if (rel_own) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            write_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            write_q <= write_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt_o   = gnt_q;
    assign bus.en_o    = en_q;
    assign bus.write_o = write_q;
    assign bus.owner_o = owner_q;
    assign bus.busy_o  = busy_q;
endmodule
